// File: rtl/multi_seq_pkg.sv
// -----------------------------------------------------------------------------
// multi_seq_pkg
//
// Purpose : Shared definitions for the multi_seq sequencer and its config
//           slice multiplexer: FSM state encoding, completion status codes,
//           default parameter values and the index-width helper used to size
//           select buses.
//
// Contents:
//   DEF_NUM_SEQ / DEF_CNT_W / DEF_NUM_SYNC : default parameter values
//   state_e                                : sequencer FSM states
//   STATUS_OK / STATUS_TIMEOUT             : values driven on status with done
//   idx_w()                                : width of an index into n items
// -----------------------------------------------------------------------------
package multi_seq_pkg;

    // Default build: four sequences, 8-bit counters, two sync lines.
    localparam int unsigned DEF_NUM_SEQ  = 4;
    localparam int unsigned DEF_CNT_W    = 8;
    localparam int unsigned DEF_NUM_SYNC = 2;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_SYNC = 2'd1,
        ST_RUN       = 2'd2,
        ST_DONE      = 2'd3
    } state_e;

    localparam logic [1:0] STATUS_OK      = 2'd0;
    localparam logic [1:0] STATUS_TIMEOUT = 2'd1;

    // Width of an index selecting one of n items. A single item still gets a
    // one-bit index so no bus ever collapses to zero width.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? int'($clog2(n)) : 1;
    endfunction

endpackage : multi_seq_pkg

// File: rtl/seq_cfg_mux.sv
// -----------------------------------------------------------------------------
// seq_cfg_mux
//
// Purpose : Combinational selection of one sequence's configuration slice out
//           of the flattened per-sequence configuration buses. An index that
//           names no sequence yields an all-zero slice; the sequencer never
//           launches on such an index, so the value is only a safe default.
//
// Ports   :
//   sel_i          in   SEL_W            sequence index
//   cfg_len_i      in   NUM_SEQ*CNT_W    run length, slice i = sequence i
//   cfg_rep_i      in   NUM_SEQ*CNT_W    extra passes, slice i = sequence i
//   cfg_sync_en_i  in   NUM_SEQ          sync-wait enable per sequence
//   cfg_sync_idx_i in   NUM_SEQ*SYNC_W   sync line per sequence
//   len_o          out  CNT_W            selected run length
//   rep_o          out  CNT_W            selected extra passes
//   sync_en_o      out  1                selected sync-wait enable
//   sync_idx_o     out  SYNC_W           selected sync line
// -----------------------------------------------------------------------------
module seq_cfg_mux
    import multi_seq_pkg::*;
#(
    parameter  int unsigned NUM_SEQ  = DEF_NUM_SEQ,
    parameter  int unsigned CNT_W    = DEF_CNT_W,
    parameter  int unsigned NUM_SYNC = DEF_NUM_SYNC,
    localparam int unsigned SEL_W    = idx_w(NUM_SEQ),
    localparam int unsigned SYNC_W   = idx_w(NUM_SYNC)
) (
    input  logic [SEL_W-1:0]          sel_i,
    input  logic [NUM_SEQ*CNT_W-1:0]  cfg_len_i,
    input  logic [NUM_SEQ*CNT_W-1:0]  cfg_rep_i,
    input  logic [NUM_SEQ-1:0]        cfg_sync_en_i,
    input  logic [NUM_SEQ*SYNC_W-1:0] cfg_sync_idx_i,
    output logic [CNT_W-1:0]          len_o,
    output logic [CNT_W-1:0]          rep_o,
    output logic                      sync_en_o,
    output logic [SYNC_W-1:0]         sync_idx_o
);

    // Comparing against each legal index (rather than a variable part-select)
    // keeps out-of-range indices from reading past the end of the buses.
    always_comb begin
        // NOTE: every output gets a default before the loop; an output left
        // unassigned on some path would infer a latch.
        len_o      = '0;
        rep_o      = '0;
        sync_en_o  = 1'b0;
        sync_idx_o = '0;
        for (int i = 0; i < NUM_SEQ; i++) begin
            if (sel_i == SEL_W'(i)) begin
                len_o      = cfg_len_i[i*CNT_W +: CNT_W];
                rep_o      = cfg_rep_i[i*CNT_W +: CNT_W];
                sync_en_o  = cfg_sync_en_i[i];
                sync_idx_o = cfg_sync_idx_i[i*SYNC_W +: SYNC_W];
            end
        end
    end

endmodule : seq_cfg_mux

// File: rtl/multi_seq.sv
// -----------------------------------------------------------------------------
// multi_seq
//
// Purpose : Launches one of NUM_SEQ configurable sequences. A sequence may
//           first wait for an external sync line (optionally bounded by a
//           timeout), then runs for len cycles per pass over rep+1 passes and
//           finishes with a one-cycle done pulse carrying a status code. The
//           configuration of the launched sequence is captured at launch, so
//           the config buses may change freely while it is active.
//
// Ports   :
//   clk           in   1                 clock, rising edge
//   reset_n       in   1                 synchronous active-low reset
//   start         in   1                 launch request (honoured in IDLE only)
//   seq_sel       in   SEL_W             sequence to launch
//   abort         in   1                 terminate the active sequence
//   ext_sync      in   NUM_SYNC          external sync levels
//   cfg_len       in   NUM_SEQ*CNT_W     run length per sequence
//   cfg_rep       in   NUM_SEQ*CNT_W     extra passes per sequence
//   cfg_sync_en   in   NUM_SEQ           sequence waits for sync first
//   cfg_sync_idx  in   NUM_SEQ*SYNC_W    sync line per sequence
//   cfg_timeout   in   CNT_W             sync-wait limit, 0 = unbounded
//   running       out  1                 high in WAIT_SYNC and RUN
//   done          out  1                 completion pulse
//   status        out  2                 STATUS_OK / STATUS_TIMEOUT with done
//   aborted       out  1                 pulse after an abort took effect
//   bad_sel       out  1                 pulse after start with a bad index
//   active_seq    out  SEL_W             latched index of current sequence
//   step          out  CNT_W             cycle within current pass
//   pass          out  CNT_W             current pass number
//
// All outputs are registers loaded from the next-state values, so each one
// describes the state the machine occupies during the same cycle.
// -----------------------------------------------------------------------------
module multi_seq
    import multi_seq_pkg::*;
#(
    parameter  int unsigned NUM_SEQ  = DEF_NUM_SEQ,
    parameter  int unsigned CNT_W    = DEF_CNT_W,
    parameter  int unsigned NUM_SYNC = DEF_NUM_SYNC,
    localparam int unsigned SEL_W    = idx_w(NUM_SEQ),
    localparam int unsigned SYNC_W   = idx_w(NUM_SYNC)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic [SEL_W-1:0]          seq_sel,
    input  logic                      abort,
    input  logic [NUM_SYNC-1:0]       ext_sync,
    input  logic [NUM_SEQ*CNT_W-1:0]  cfg_len,
    input  logic [NUM_SEQ*CNT_W-1:0]  cfg_rep,
    input  logic [NUM_SEQ-1:0]        cfg_sync_en,
    input  logic [NUM_SEQ*SYNC_W-1:0] cfg_sync_idx,
    input  logic [CNT_W-1:0]          cfg_timeout,
    output logic                      running,
    output logic                      done,
    output logic [1:0]                status,
    output logic                      aborted,
    output logic                      bad_sel,
    output logic [SEL_W-1:0]          active_seq,
    output logic [CNT_W-1:0]          step,
    output logic [CNT_W-1:0]          pass
);

    // ---------------------------------------------------------------------
    // Declarations
    // ---------------------------------------------------------------------
    state_e state_q, state_d;

    // Slice of the sequence named by seq_sel (valid only while launching).
    logic [CNT_W-1:0]  mux_len;
    logic [CNT_W-1:0]  mux_rep;
    logic              mux_sync_en;
    logic [SYNC_W-1:0] mux_sync_idx;

    // Configuration captured at launch.
    logic [SEL_W-1:0]  act_seq_q,  act_seq_d;
    logic [CNT_W-1:0]  len_q,      len_d;
    logic [CNT_W-1:0]  rep_q,      rep_d;
    logic              sync_en_q,  sync_en_d;
    logic [SYNC_W-1:0] sync_idx_q, sync_idx_d;
    logic [CNT_W-1:0]  timeout_q,  timeout_d;

    // Counters.
    logic [CNT_W-1:0]  step_q, step_d;
    logic [CNT_W-1:0]  pass_q, pass_d;
    logic [CNT_W-1:0]  wait_q, wait_d;

    // Registered outputs.
    logic              running_q, running_d;
    logic              done_q,    done_d;
    logic [1:0]        status_q,  status_d;
    logic              aborted_q, aborted_d;
    logic              bad_sel_q, bad_sel_d;

    logic sel_ok;
    logic launch;
    logic sync_hit;
    logic timeout_hit;
    logic last_step;

    // ---------------------------------------------------------------------
    // Config slice selection
    // ---------------------------------------------------------------------
    seq_cfg_mux #(
        .NUM_SEQ  (NUM_SEQ),
        .CNT_W    (CNT_W),
        .NUM_SYNC (NUM_SYNC)
    ) u_cfg_mux (
        .sel_i          (seq_sel),
        .cfg_len_i      (cfg_len),
        .cfg_rep_i      (cfg_rep),
        .cfg_sync_en_i  (cfg_sync_en),
        .cfg_sync_idx_i (cfg_sync_idx),
        .len_o          (mux_len),
        .rep_o          (mux_rep),
        .sync_en_o      (mux_sync_en),
        .sync_idx_o     (mux_sync_idx)
    );

    // ---------------------------------------------------------------------
    // Decode
    // ---------------------------------------------------------------------
    // Zero-extend by one bit so the compare holds for any NUM_SEQ, including
    // a power of two where every encodable index is legal.
    assign sel_ok = ({1'b0, seq_sel} < (SEL_W + 1)'(NUM_SEQ));

    // abort outranks start in IDLE: the request is dropped silently.
    assign launch = (state_q == ST_IDLE) && start && !abort && sel_ok;

    assign sync_hit = sync_en_q && ext_sync[sync_idx_q];

    // wait_q holds the number of WAIT_SYNC cycles already completed, so the
    // limit is reached at the edge that closes the timeout-th cycle.
    assign timeout_hit = (timeout_q != '0) && (wait_q == timeout_q - CNT_W'(1));

    // Only consulted in RUN, where len_q is never zero.
    assign last_step = (step_q == len_q - CNT_W'(1));

    // ---------------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------------
    // NOTE: reset_n is sampled inside the clocked block and is absent from the
    // sensitivity list, which makes the reset synchronous.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register in the design
        // samples the values that existed before this edge.
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (launch) begin
                    if (mux_sync_en) begin
                        state_d = ST_WAIT_SYNC;
                    end else if (mux_len != '0) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_WAIT_SYNC: begin
                // A sync sampled on the same edge as the timeout wins.
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (sync_hit) begin
                    state_d = (len_q != '0) ? ST_RUN : ST_DONE;
                end else if (timeout_hit) begin
                    state_d = ST_DONE;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (last_step && (pass_q >= rep_q)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Datapath and output next values
    // ---------------------------------------------------------------------
    always_comb begin
        act_seq_d  = act_seq_q;
        len_d      = len_q;
        rep_d      = rep_q;
        sync_en_d  = sync_en_q;
        sync_idx_d = sync_idx_q;
        timeout_d  = timeout_q;
        step_d     = '0;
        pass_d     = '0;
        wait_d     = '0;

        if (launch) begin
            act_seq_d  = seq_sel;
            len_d      = mux_len;
            rep_d      = mux_rep;
            sync_en_d  = mux_sync_en;
            sync_idx_d = mux_sync_idx;
            timeout_d  = cfg_timeout;
        end

        // Counters advance only while the state is held; any entry into RUN
        // or WAIT_SYNC therefore starts them from zero.
        if ((state_q == ST_RUN) && (state_d == ST_RUN)) begin
            if (last_step) begin
                pass_d = pass_q + CNT_W'(1);
            end else begin
                step_d = step_q + CNT_W'(1);
                pass_d = pass_q;
            end
        end

        // Saturate so an unbounded wait cannot wrap the counter.
        if ((state_q == ST_WAIT_SYNC) && (state_d == ST_WAIT_SYNC)) begin
            wait_d = (wait_q == '1) ? wait_q : wait_q + CNT_W'(1);
        end

        running_d = (state_d == ST_WAIT_SYNC) || (state_d == ST_RUN);
        done_d    = (state_d == ST_DONE);

        // Leaving WAIT_SYNC for DONE without a sync can only be the timeout.
        status_d = STATUS_OK;
        if ((state_q == ST_WAIT_SYNC) && (state_d == ST_DONE) && !sync_hit) begin
            status_d = STATUS_TIMEOUT;
        end

        aborted_d = abort && (state_q != ST_IDLE);
        bad_sel_d = (state_q == ST_IDLE) && start && !abort && !sel_ok;
    end

    // ---------------------------------------------------------------------
    // Datapath and output registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            act_seq_q  <= '0;
            len_q      <= '0;
            rep_q      <= '0;
            sync_en_q  <= 1'b0;
            sync_idx_q <= '0;
            timeout_q  <= '0;
            step_q     <= '0;
            pass_q     <= '0;
            wait_q     <= '0;
            running_q  <= 1'b0;
            done_q     <= 1'b0;
            status_q   <= STATUS_OK;
            aborted_q  <= 1'b0;
            bad_sel_q  <= 1'b0;
        end else begin
            act_seq_q  <= act_seq_d;
            len_q      <= len_d;
            rep_q      <= rep_d;
            sync_en_q  <= sync_en_d;
            sync_idx_q <= sync_idx_d;
            timeout_q  <= timeout_d;
            step_q     <= step_d;
            pass_q     <= pass_d;
            wait_q     <= wait_d;
            running_q  <= running_d;
            done_q     <= done_d;
            status_q   <= status_d;
            aborted_q  <= aborted_d;
            bad_sel_q  <= bad_sel_d;
        end
    end

    assign running    = running_q;
    assign done       = done_q;
    assign status     = status_q;
    assign aborted    = aborted_q;
    assign bad_sel    = bad_sel_q;
    assign active_seq = act_seq_q;
    assign step       = step_q;
    assign pass       = pass_q;

endmodule : multi_seq

// File: tb/tb_multi_seq.sv
// -----------------------------------------------------------------------------
// tb_multi_seq
//
// Self-checking bench for multi_seq, built with five sequences so that index 4
// is legal and indices 5..7 are rejected. Expected behaviour comes from a
// timeline model: a launch at edge E0 gives W wait cycles, then len*(rep+1)
// run cycles, then one done cycle, where W follows from when the sync line is
// raised and from the timeout.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_multi_seq;

    localparam int NS     = 5;
    localparam int CW     = 8;
    localparam int NY     = 2;
    localparam int SEL_W  = 3;
    localparam int SYNC_W = 1;

    logic                   clk;
    logic                   reset_n;
    logic                   start;
    logic [SEL_W-1:0]       seq_sel;
    logic                   abort;
    logic [NY-1:0]          ext_sync;
    logic [NS*CW-1:0]       cfg_len;
    logic [NS*CW-1:0]       cfg_rep;
    logic [NS-1:0]          cfg_sync_en;
    logic [NS*SYNC_W-1:0]   cfg_sync_idx;
    logic [CW-1:0]          cfg_timeout;
    logic                   running;
    logic                   done;
    logic [1:0]             status;
    logic                   aborted;
    logic                   bad_sel;
    logic [SEL_W-1:0]       active_seq;
    logic [CW-1:0]          step;
    logic [CW-1:0]          pass;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference configuration, one entry per sequence.
    int m_len  [NS];
    int m_rep  [NS];
    int m_sen  [NS];
    int m_sidx [NS];
    int m_timeout;

    multi_seq #(
        .NUM_SEQ  (NS),
        .CNT_W    (CW),
        .NUM_SYNC (NY)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .seq_sel      (seq_sel),
        .abort        (abort),
        .ext_sync     (ext_sync),
        .cfg_len      (cfg_len),
        .cfg_rep      (cfg_rep),
        .cfg_sync_en  (cfg_sync_en),
        .cfg_sync_idx (cfg_sync_idx),
        .cfg_timeout  (cfg_timeout),
        .running      (running),
        .done         (done),
        .status       (status),
        .aborted      (aborted),
        .bad_sel      (bad_sel),
        .active_seq   (active_seq),
        .step         (step),
        .pass         (pass)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, " running"},    32'(running),    32'(0));
        check({tag, " done"},       32'(done),       32'(0));
        check({tag, " status"},     32'(status),     32'(0));
        check({tag, " aborted"},    32'(aborted),    32'(0));
        check({tag, " bad_sel"},    32'(bad_sel),    32'(0));
        check({tag, " active_seq"}, 32'(active_seq), 32'(0));
        check({tag, " step"},       32'(step),       32'(0));
        check({tag, " pass"},       32'(pass),       32'(0));
    endtask

    task automatic apply_cfg();
        for (int i = 0; i < NS; i++) begin
            cfg_len[i*CW +: CW]               = CW'(m_len[i]);
            cfg_rep[i*CW +: CW]               = CW'(m_rep[i]);
            cfg_sync_en[i]                    = (m_sen[i] != 0);
            cfg_sync_idx[i*SYNC_W +: SYNC_W]  = SYNC_W'(m_sidx[i]);
        end
        cfg_timeout = CW'(m_timeout);
    endtask

    // Launches sequence sel at the next edge (caller is at a negedge) and
    // checks every following cycle against the timeline model.
    //   sync_c    : cycle in which the sequence's sync line is raised (0 = never)
    //   other     : level held on the sync line the sequence does not watch
    //   abort_c   : cycle in which abort is driven (0 = none, -1 = random)
    //   restart_c : cycle in which a stray start is driven (0 = none, -1 = random)
    //   scramble  : overwrite the config buses right after launch
    task automatic run_seq(input int sel, input int sync_c, input int other,
                           input int abort_c, input int restart_c, input bit scramble);
        int  l, r, sen, sidx, t, w, d, a, rs, last, k;
        bit  tmo, e_run, e_done, e_abt, in_run;
        string tg;
        l = m_len[sel]; r = m_rep[sel]; sen = m_sen[sel]; sidx = m_sidx[sel];
        t = m_timeout;
        tmo = 1'b0;
        w = 0;
        if (sen != 0) begin
            if ((t != 0) && ((sync_c <= 0) || (sync_c > t))) begin
                w = t; tmo = 1'b1;
            end else begin
                w = sync_c;
            end
        end
        d = tmo ? w + 1 : w + l * (r + 1) + 1;
        a = abort_c;
        if (a < 0) a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, d)) : 0;
        rs = restart_c;
        if (rs < 0) rs = int'($urandom_range(1, d));
        if ((a > 0) && (rs > a)) rs = 0;
        last = (a > 0) ? a + 2 : d + 2;

        apply_cfg();
        seq_sel = SEL_W'(sel);
        start   = 1'b1;
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            // Inputs for the edge that ends cycle c.
            start = (c == rs);
            if (c == rs) seq_sel = SEL_W'((sel + 1) % NS);
            abort = (c == a);
            ext_sync = '0;
            ext_sync[1 - sidx] = (other != 0);
            if ((sen != 0) && (sync_c > 0) && (c >= sync_c)) ext_sync[sidx] = 1'b1;
            if (scramble && (c == 1)) begin
                cfg_len      = (NS*CW)'({$urandom(), $urandom()});
                cfg_rep      = (NS*CW)'({$urandom(), $urandom()});
                cfg_sync_en  = NS'($urandom());
                cfg_sync_idx = (NS*SYNC_W)'($urandom());
                cfg_timeout  = CW'($urandom());
            end
            // Outputs of cycle c.
            tg = $sformatf("seq%0d c%0d", sel, c);
            if ((a > 0) && (c > a)) begin
                e_run = 1'b0; e_done = 1'b0; e_abt = (c == a + 1); in_run = 1'b0;
            end else begin
                e_run  = (c < d);
                e_done = (c == d);
                e_abt  = 1'b0;
                in_run = !tmo && (c > w) && (c < d);
                check({tg, " active_seq"}, 32'(active_seq), 32'(sel));
            end
            check({tg, " running"}, 32'(running), 32'(e_run));
            check({tg, " done"},    32'(done),    32'(e_done));
            check({tg, " status"},  32'(status),  32'((e_done && tmo) ? 1 : 0));
            check({tg, " aborted"}, 32'(aborted), 32'(e_abt));
            check({tg, " bad_sel"}, 32'(bad_sel), 32'(0));
            if (in_run) begin
                k = c - w - 1;
                check({tg, " step"}, 32'(step), 32'(k % l));
                check({tg, " pass"}, 32'(pass), 32'(k / l));
            end
        end
        start    = 1'b0;
        abort    = 1'b0;
        ext_sync = '0;
        apply_cfg();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sel, sync_c, other;

        m_len  = '{10, 5, 4, 0, 3};
        m_rep  = '{ 0, 0, 2, 0, 0};
        m_sen  = '{ 0, 1, 0, 0, 0};
        m_sidx = '{ 0, 1, 0, 0, 0};
        m_timeout = 0;
        reset_n  = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        seq_sel  = '0;
        ext_sync = '0;
        apply_cfg();

        // Reset state.
        repeat (3) @(negedge clk);
        check_idle_zero("reset");

        // Start on the first edge after reset release: len=10, rep=0.
        reset_n = 1'b1;
        run_seq(0, 0, 0, 0, 0, 1'b0);

        // Sync on line 1 raised in cycle 15 (line 0 high throughout): 15+5.
        run_seq(1, 15, 1, 0, 0, 1'b0);

        // len=4, rep=2 with config changed under it: 12 cycles, 3 passes.
        run_seq(2, 0, 0, 0, 0, 1'b1);

        // Sync never arrives, timeout=8: 8 waiting cycles then status 1.
        m_timeout = 8;
        run_seq(1, 0, 1, 0, 0, 1'b0);
        m_timeout = 0;

        // Stray start in RUN at cycle 2, abort at step 3 (cycle 4).
        run_seq(0, 0, 0, 4, 2, 1'b0);

        // len=0: done in the first cycle, running never high.
        run_seq(3, 0, 0, 0, 0, 1'b0);

        // Index 4 is legal in a five-sequence build; stray start during DONE.
        run_seq(4, 0, 0, 0, 4, 1'b0);

        // Indices 5 and 7 are rejected with a single bad_sel pulse.
        seq_sel = 3'd5; start = 1'b1;
        @(negedge clk); start = 1'b0;
        check("bad5 pulse",   32'(bad_sel), 32'(1));
        check("bad5 running", 32'(running), 32'(0));
        @(negedge clk);
        check("bad5 one-shot", 32'(bad_sel), 32'(0));
        check("bad5 idle",     32'(running), 32'(0));
        seq_sel = 3'd7; start = 1'b1;
        @(negedge clk); start = 1'b0;
        check("bad7 pulse", 32'(bad_sel), 32'(1));
        @(negedge clk);
        check("bad7 one-shot", 32'(bad_sel), 32'(0));

        // abort together with start in IDLE: nothing happens.
        seq_sel = 3'd0; start = 1'b1; abort = 1'b1;
        @(negedge clk); start = 1'b0; abort = 1'b0;
        check("idle abort running", 32'(running), 32'(0));
        check("idle abort aborted", 32'(aborted), 32'(0));
        check("idle abort done",    32'(done),    32'(0));
        check("idle abort bad_sel", 32'(bad_sel), 32'(0));
        @(negedge clk);
        check("idle abort stays idle", 32'(running), 32'(0));

        // Reset in the middle of seq2's second pass clears everything.
        apply_cfg();
        seq_sel = 3'd2; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (5) @(negedge clk);
        check("pre-reset running", 32'(running), 32'(1));
        check("pre-reset pass",    32'(pass),    32'(1));
        check("pre-reset step",    32'(step),    32'(1));
        reset_n = 1'b0;
        @(negedge clk);
        check_idle_zero("mid-run reset");
        reset_n = 1'b1;
        @(negedge clk);
        check_idle_zero("after reset release");

        // Randomised sequences against the timeline model.
        for (int it = 0; it < 20; it++) begin
            sel = int'($urandom_range(0, NS - 1));
            m_len[sel]  = int'($urandom_range(0, 6));
            m_rep[sel]  = int'($urandom_range(0, 2));
            m_sen[sel]  = int'($urandom_range(0, 1));
            m_sidx[sel] = int'($urandom_range(0, 1));
            m_timeout   = int'($urandom_range(0, 6));
            sync_c      = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 9));
            if (m_timeout == 0 && sync_c == 0) sync_c = int'($urandom_range(1, 9));
            other       = int'($urandom_range(0, 1));
            run_seq(sel, sync_c, other, -1, -1, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_multi_seq
